// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the 2:1 multiplexer primitive used to build the full adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic mux2(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/full_adder_mux.sv
// Purely combinational 1-bit full adder built only from 2:1 multiplexers.
module full_adder_mux
    import serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    logic axb;

    // When a and b differ the carry propagates c; otherwise a (== b) is the carry.
    assign axb  = mux2(a_i, b_i, ~b_i);
    assign s_o  = mux2(axb, c_i, ~c_i);
    assign co_o = mux2(axb, a_i, c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per cycle through a single full adder,
// LSB first, result assembled by shifting into the top of the sum register.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    ra_q, ra_d;
    logic [N-1:0]    rb_q, rb_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   count_q, count_d;

    logic            fa_s;
    logic            fa_co;

    full_adder_mux u_fa (
        .a_i  (ra_q[0]),
        .b_i  (rb_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;

        case (state_q)
            IDLE, FIN: begin
                // FIN accepts start like IDLE so operations can run back-to-back.
                if (start) begin
                    state_d = ADD;
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    count_d = '0;
                    sum_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                sum_d   = {fa_s, sum_q[N-1:1]};
                carry_d = fa_co;
                if (count_q == LAST) begin
                    state_d = FIN;
                    cout_d  = fa_co;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == FIN);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N=8 scenarios plus exhaustive N=4).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one N=8 operation, check busy for N cycles, then check the FIN cycle.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'(busy8), 32'h1);
            chk({tag, "_nodone"}, 32'(done8), 32'h0);
            tick();
        end
        chk({tag, "_done"}, 32'(done8), 32'h1);
        chk({tag, "_busy_fin"}, 32'(busy8), 32'h0);
        chk({tag, "_sum"}, 32'(sum8), 32'(es));
        chk({tag, "_cout"}, 32'(cout8), 32'(ec));
        tick();
        chk({tag, "_done_gone"}, 32'(done8), 32'h0);
        chk({tag, "_sum_hold"}, 32'(sum8), 32'(es));
        chk({tag, "_cout_hold"}, 32'(cout8), 32'(ec));
    endtask

    logic [7:0]  opa [3];
    logic [7:0]  opb [3];
    logic        opc [3];
    logic [7:0]  exs [3];
    logic        exc [3];

    initial begin
        int unsigned n;
        int unsigned last_cyc;
        bit          seen_done;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #1;
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_done", 32'(done8), 32'h0);
        chk("rst_sum",  32'(sum8),  32'h0);
        chk("rst_cout", 32'(cout8), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // First start right after reset release; 0xFF + 0x01 overflows to 0 with carry.
        run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("5a_3c", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0);

        // Start held through ADD with new operands: ignored until FIN.
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h11; b8 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            chk("hold_busy", 32'(busy8), 32'h1);
            tick();
        end
        chk("hold_done1", 32'(done8), 32'h1);
        chk("hold_sum1",  32'(sum8),  32'h10);
        chk("hold_cout1", 32'(cout8), 32'h0);
        tick();
        start8 = 1'b0;
        chk("hold_busy2", 32'(busy8), 32'h1);
        repeat (8) tick();
        chk("hold_done2", 32'(done8), 32'h1);
        chk("hold_sum2",  32'(sum8),  32'h33);
        chk("hold_cout2", 32'(cout8), 32'h0);
        tick();

        // Reset during ADD cycle 4 abandons the operation.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", 32'(busy8), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy8), 32'h0);
        chk("mid_done", 32'(done8), 32'h0);
        chk("mid_sum",  32'(sum8),  32'h0);
        chk("mid_cout", 32'(cout8), 32'h0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen_done = 1'b1;
        end
        chk("mid_no_done", 32'(seen_done), 32'h0);
        chk("mid_sum_after", 32'(sum8), 32'h0);

        // Back-to-back: start held for three operations.
        opa[0] = 8'h01; opb[0] = 8'h02; opc[0] = 1'b0; exs[0] = 8'h03; exc[0] = 1'b0;
        opa[1] = 8'h80; opb[1] = 8'h80; opc[1] = 1'b0; exs[1] = 8'h00; exc[1] = 1'b1;
        opa[2] = 8'h7F; opb[2] = 8'h01; opc[2] = 1'b1; exs[2] = 8'h81; exc[2] = 1'b0;
        a8 = opa[0]; b8 = opb[0]; cin8 = opc[0]; start8 = 1'b1;
        tick();
        a8 = opa[1]; b8 = opb[1]; cin8 = opc[1];
        last_cyc = 0;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!done8 && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_done", 32'(done8), 32'h1);
            chk("b2b_sum",  32'(sum8),  32'(exs[j]));
            chk("b2b_cout", 32'(cout8), 32'(exc[j]));
            if (j > 0) chk("b2b_spacing", cyc - last_cyc, 32'd9);
            last_cyc = cyc;
            if (j < 2) begin
                tick();
                if (j == 0) begin
                    a8 = opa[2]; b8 = opb[2]; cin8 = opc[2];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        tick();

        // Exhaustive N=4.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    repeat (4) tick();
                    chk("n4_done", 32'(done4), 32'h1);
                    chk("n4_result", 32'({cout4, sum4}), 32'(ai + bi + ci));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 a  input  N  operand A; captured on the accepted start edge only.
REQ-006 b  input  N  operand B; captured on the accepted start edge only.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge only.
REQ-008 busy  output  1  high while a bit-serial addition is in progress.
REQ-009 done  output  1  single-cycle pulse; sum/cout valid.
REQ-010 sum  output  N  result a+b+cin modulo 2^N; held until next accepted start.
REQ-011 cout  output  1  carry-out of bit N-1; held with sum.

Function
REQ-012 The FSM SHALL have three states: IDLE, ADD, FIN.
REQ-013 IDLE: start=1 SHALL load shift registers ra<=a, rb<=b, carry<=cin, count<=0, sum<=0, and move to ADD; start=0 stays IDLE.
REQ-014 ADD: each cycle SHALL feed ra[0], rb[0], carry into one full-adder instance, shift ra and rb right by one, shift the full-adder sum bit into sum[N-1] while shifting sum right, load carry with the full-adder carry, and increment count.
REQ-015 ADD SHALL last exactly N cycles; on the edge where count reaches N-1, the FSM SHALL move to FIN with cout<=full-adder carry.
REQ-016 done SHALL be high for exactly the one cycle the FSM is in FIN; busy SHALL be high exactly while in ADD.
REQ-017 Latency: with start accepted on edge k, done SHALL be observed high in the cycle following edge k+N.
REQ-018 FIN SHALL return to IDLE on the next edge; start=1 in FIN SHALL be accepted exactly as in IDLE (back-to-back, no idle bubble).
REQ-019 start while in ADD SHALL be ignored; operands and result in flight SHALL be unaffected.
REQ-020 sum and cout SHALL change only during ADD/FIN of an accepted operation and on reset; they SHALL hold between operations.
REQ-021 The count register SHALL be ceil(log2(N)) bits and SHALL never wrap within an operation.
REQ-022 The full adder SHALL compute s=a^b^c and co=majority(a,b,c); no other arithmetic path SHALL exist.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, count=0, ra=0, rb=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow reset release.
REQ-025 The first start SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the state enumeration (IDLE, ADD, FIN) and the default width constant (8).
REQ-027 One sub-module full_adder_mux SHALL implement the 1-bit full adder from 2:1 multiplexer primitives; serial_adder SHALL instantiate it exactly once.
REQ-028 All registers SHALL reside in serial_adder; full_adder_mux SHALL be purely combinational.

Verification
REQ-029 N=8, a=8'hFF, b=8'h01, cin=0, start pulse -> busy high 8 cycles, done pulse, sum=8'h00, cout=1.
REQ-030 N=8, a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0; done exactly 8 cycles after start edge.
REQ-031 Start held high during ADD with new a=8'h11,b=8'h22 -> ignored; first result correct; second operation begins only from FIN, yielding sum=8'h33.
REQ-032 rst_n pulsed low at ADD cycle 4 -> all outputs 0 immediately, state IDLE, no done pulse afterwards.
REQ-033 Back-to-back: start held continuously for 3 operations -> done pulses spaced N+1 cycles, each sum/cout correct.
REQ-034 N=4: exhaustive a,b in 0..15, cin in {0,1} -> {cout,sum} equals a+b+cin for all 512 cases.
